// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter: NUM_INPUTS AXI-Stream slaves share one
// registered AXI-Stream master. A grant is held from the first beat through tlast.

module axis_rr_lane #(
  parameter int ID_W = 2,
  parameter int IDX  = 0
) (
  input  logic            granted,
  input  logic [ID_W-1:0] grant_id,
  input  logic            ld,
  input  logic            tvalid,
  output logic            tready,
  output logic            take
);
  assign tready = granted && (grant_id == ID_W'(IDX)) && ld;
  assign take   = tready && tvalid;
endmodule

module axis_rr_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_INPUTS = 4,
  parameter int ID_W       = $clog2(NUM_INPUTS)
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_INPUTS-1:0]            s_tvalid,
  input  logic [NUM_INPUTS-1:0]            s_tlast,
  output logic [NUM_INPUTS-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]            m_tdata,
  output logic                             m_tvalid,
  output logic                             m_tlast,
  input  logic                             m_tready,
  output logic [ID_W-1:0]                  grant_id,
  output logic                             busy
);
  typedef enum logic {IDLE, GRANTED} state_t;

  state_t                  state;
  logic [ID_W-1:0]         last_grant;
  logic [ID_W-1:0]         winner;
  logic                    found;
  logic                    ld;
  logic                    acc;
  logic [NUM_INPUTS-1:0]   take;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    sel_last;
  int                      idx;

  assign ld   = !m_tvalid || m_tready;
  assign busy = (state == GRANTED);
  assign acc  = |take;

  genvar i;
  generate
    for (i = 0; i < NUM_INPUTS; i++) begin : g_lane
      axis_rr_lane #(.ID_W(ID_W), .IDX(i)) u_lane (
        .granted  (state == GRANTED),
        .grant_id (grant_id),
        .ld       (ld),
        .tvalid   (s_tvalid[i]),
        .tready   (s_tready[i]),
        .take     (take[i])
      );
    end
  endgenerate

  assign sel_data = s_tdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign sel_last = s_tlast[grant_id];

  // Rotating priority scan: the input just after the last winner goes first.
  always_comb begin
    found  = 1'b0;
    winner = last_grant;
    idx    = 0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      idx = (int'(last_grant) + k) % NUM_INPUTS;
      if (!found && s_tvalid[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= IDLE;
      m_tvalid   <= 1'b0;
      m_tdata    <= '0;
      m_tlast    <= 1'b0;
      grant_id   <= '0;
      last_grant <= ID_W'(NUM_INPUTS - 1);
    end else begin
      // Output register also drains in IDLE so a held tlast beat can leave.
      if (ld) begin
        if (acc) begin
          m_tdata  <= sel_data;
          m_tlast  <= sel_last;
          m_tvalid <= 1'b1;
        end else begin
          m_tvalid <= 1'b0;
        end
      end
      case (state)
        IDLE: begin
          if (found) begin
            grant_id <= winner;
            state    <= GRANTED;
          end
        end
        GRANTED: begin
          if (acc && sel_last) begin
            state      <= IDLE;
            last_grant <= grant_id;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: directed packets push expected beats,
// a negedge monitor pops and compares every master handshake.

module tb_axis_rr_arbiter;
  localparam int DW = 64;
  localparam int NI = 4;
  localparam int IW = 2;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    logic [IW-1:0] g;
  } exp_t;

  logic             aclk = 1'b0;
  logic             areset = 1'b1;
  logic [NI*DW-1:0] s_tdata = '0;
  logic [NI-1:0]    s_tvalid = '0;
  logic [NI-1:0]    s_tlast = '0;
  logic [NI-1:0]    s_tready;
  logic [DW-1:0]    m_tdata;
  logic             m_tvalid;
  logic             m_tlast;
  logic             m_tready = 1'b1;
  logic [IW-1:0]    grant_id;
  logic             busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  exp_t exp_q[$];
  int   out_cyc[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_d;
  logic          prev_l;
  logic          done0;

  axis_rr_arbiter #(.DATA_WIDTH(DW), .NUM_INPUTS(NI)) dut (
    .aclk(aclk), .areset(areset),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every master handshake is popped against the scoreboard.
  always @(negedge aclk) begin
    if (!areset && prev_stall) begin
      check("stall_valid", 64'(m_tvalid), 64'd1);
      check("stall_data", m_tdata, prev_d);
      check("stall_last", 64'(m_tlast), 64'(prev_l));
    end
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", m_tdata, 64'hdead_beef);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_data", m_tdata, e.d);
        check("out_last", 64'(m_tlast), 64'(e.l));
        check("out_gid", 64'(grant_id), 64'(e.g));
      end
      out_cyc.push_back(cyc);
    end
    prev_stall = m_tvalid && !m_tready && !areset;
    prev_d     = m_tdata;
    prev_l     = m_tlast;
  end

  task automatic push(input logic [DW-1:0] d, input logic l, input logic [IW-1:0] g);
    exp_t e;
    e.d = d; e.l = l; e.g = g;
    exp_q.push_back(e);
  endtask

  // Drive one packet on input src; data = base+k; optional valid hole before beat hole_at.
  task automatic send_pkt(input int src, input logic [DW-1:0] base, input int n,
                          input int hole_at, input int hole_len);
    for (int k = 0; k < n; k++) begin
      int t;
      if (k == hole_at && hole_len > 0) begin
        s_tvalid[src] = 1'b0;
        repeat (hole_len) @(posedge aclk);
        #1;
      end
      s_tdata[src*DW +: DW] = base + 64'(k);
      s_tlast[src]  = (k == n - 1);
      s_tvalid[src] = 1'b1;
      t = 0;
      do begin
        @(negedge aclk);
        t++;
      end while (!s_tready[src] && t < 300);
      if (!s_tready[src]) check("handshake_timeout", 64'(src), 64'hffff);
      @(posedge aclk);
      #1;
    end
    s_tvalid[src] = 1'b0;
    s_tlast[src]  = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge aclk);
      t++;
    end
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [6:0] pat;

    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_tdata", m_tdata, 64'd0);
    check("rst_m_tlast", 64'(m_tlast), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_grant_id", 64'(grant_id), 64'd0);

    // Reset priority: 1 and 3 together, input 1 first.
    out_cyc.delete();
    push(64'h10, 1'b0, 2'd1); push(64'h11, 1'b1, 2'd1);
    push(64'h30, 1'b0, 2'd3); push(64'h31, 1'b1, 2'd3);
    fork
      send_pkt(1, 64'h10, 2, -1, 0);
      send_pkt(3, 64'h30, 2, -1, 0);
    join
    drain("prio_drain");
    if (out_cyc.size() == 4) begin
      check("prio_beat_gap", 64'(out_cyc[1] - out_cyc[0]), 64'd1);
      check("prio_pkt_bubble", 64'(out_cyc[2] - out_cyc[1]), 64'd2);
    end else check("prio_count", 64'(out_cyc.size()), 64'd4);

    // Round-robin wrap: all inputs send two 1-beat packets tagged by source.
    repeat (2) @(posedge aclk);
    #1;
    out_cyc.delete();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < NI; s++) push(64'(s), 1'b1, IW'(s));
    fork
      begin send_pkt(0, 64'd0, 1, -1, 0); send_pkt(0, 64'd0, 1, -1, 0); end
      begin send_pkt(1, 64'd1, 1, -1, 0); send_pkt(1, 64'd1, 1, -1, 0); end
      begin send_pkt(2, 64'd2, 1, -1, 0); send_pkt(2, 64'd2, 1, -1, 0); end
      begin send_pkt(3, 64'd3, 1, -1, 0); send_pkt(3, 64'd3, 1, -1, 0); end
    join
    drain("rr_drain");
    if (out_cyc.size() == 8) begin
      for (int k = 1; k < 8; k++) check("rr_bubble", 64'(out_cyc[k] - out_cyc[k-1]), 64'd2);
    end else check("rr_count", 64'(out_cyc.size()), 64'd8);

    // Backpressure: 4-beat packet on input 2 with m_tready toggling.
    repeat (2) @(posedge aclk);
    #1;
    for (int k = 0; k < 4; k++) push(64'hA0 + 64'(k), k == 3, 2'd2);
    pat = 7'b1101001;  // applied LSB first: 1,0,0,1,0,1,1
    fork
      send_pkt(2, 64'hA0, 4, -1, 0);
      begin
        for (int k = 0; k < 7; k++) begin
          m_tready = pat[k];
          @(posedge aclk);
          #1;
        end
        m_tready = 1'b1;
      end
    join
    drain("bp_drain");

    // No interleave: input 0 stalls mid-packet while input 1 requests.
    repeat (2) @(posedge aclk);
    #1;
    done0 = 1'b0;
    push(64'h40, 1'b0, 2'd0); push(64'h41, 1'b0, 2'd0); push(64'h42, 1'b1, 2'd0);
    push(64'h50, 1'b1, 2'd1);
    fork
      begin send_pkt(0, 64'h40, 3, 1, 5); done0 = 1'b1; end
      send_pkt(1, 64'h50, 1, -1, 0);
      begin
        @(posedge aclk);
        for (int t = 0; t < 100; t++) begin
          @(negedge aclk);
          if (done0) break;
          check("ni_no_ready1", 64'(s_tready[1]), 64'd0);
          check("ni_busy", 64'(busy), 64'd1);
        end
      end
    join
    drain("ni_drain");

    // Reset mid-packet on input 2, then 0 and 2 request: 0 must win.
    repeat (2) @(posedge aclk);
    #1;
    push(64'h60, 1'b0, 2'd2);
    s_tdata[2*DW +: DW] = 64'h60;
    s_tlast[2]  = 1'b0;
    s_tvalid[2] = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge aclk);
      if (s_tready[2]) break;
    end
    check("rm_first_ready", 64'(s_tready[2]), 64'd1);
    @(posedge aclk);
    #1;
    s_tdata[2*DW +: DW] = 64'h61;
    areset = 1'b1;
    @(posedge aclk);
    #1;
    check("rm_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rm_busy", 64'(busy), 64'd0);
    check("rm_s_tready", 64'(s_tready), 64'd0);
    s_tvalid[2] = 1'b0;
    areset = 1'b0;
    drain("rm_pre_drain");
    push(64'h70, 1'b1, 2'd0); push(64'h72, 1'b1, 2'd2);
    fork
      send_pkt(0, 64'h70, 1, -1, 0);
      send_pkt(2, 64'h72, 1, -1, 0);
    join
    drain("rm_drain");

    // Idle: nothing requested for 20 cycles; grant_id stays at last winner (2).
    repeat (2) @(posedge aclk);
    for (int t = 0; t < 20; t++) begin
      @(negedge aclk);
      check("idle_m_tvalid", 64'(m_tvalid), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_grant_id", 64'(grant_id), 64'd2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    bad++;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Packet-granular round-robin arbiter that shares one AXI-Stream master channel among NUM_INPUTS AXI-Stream slave channels, all carrying the `axi_stream` signal set (tdata/tvalid/tready/tlast). A grant is held for a whole packet, from the first beat through the beat with tlast, so packets are never interleaved. The output is driven from a full-throughput register stage. The block sits upstream of any single-consumer stream sink, such as a network egress or DMA write port.

## Interface

Parameters:
- DATA_WIDTH, 64, tdata width of every stream.
- NUM_INPUTS, 4, number of slave streams; legal range 2..16.
- ID_W, $clog2(NUM_INPUTS), width of the source index; derived, do not override.

Ports:
- aclk  input  1  clock; all logic on posedge.
- areset  input  1  reset; synchronous and active-high.
- s_tdata  input  NUM_INPUTS*DATA_WIDTH  slave data; input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_tvalid  input  NUM_INPUTS  per-input valid.
- s_tlast  input  NUM_INPUTS  per-input end of packet.
- s_tready  output  NUM_INPUTS  per-input ready.
- m_tdata  output  DATA_WIDTH  master data (registered).
- m_tvalid  output  1  master valid (registered).
- m_tlast  output  1  master end of packet (registered).
- m_tready  input  1  master ready.
- grant_id  output  ID_W  index of the input currently or most recently granted (registered).
- busy  output  1  1 while in state GRANTED.

## Operation

- FSM with two states: IDLE and GRANTED.
- **IDLE**
  - Scan s_tvalid starting at index (last_grant+1) mod NUM_INPUTS, wrapping around.
  - The first asserted input wins. At the next edge: grant_id <= winner, state <= GRANTED.
  - If no input is valid, stay in IDLE.
  - In IDLE every s_tready bit is 0.
- **GRANTED**
  - Output register load enable: `ld = !m_tvalid || m_tready`.
  - s_tready[grant_id] = ld; all other s_tready bits are 0.
  - An input beat is accepted when s_tvalid[grant_id] && s_tready[grant_id]. On acceptance the register loads m_tdata, m_tlast and sets m_tvalid=1.
  - If ld is high and no beat is accepted: m_tvalid <= 0.
  - If ld is low: the register holds its contents.
  - When the accepted beat has tlast=1:
    - state <= IDLE
    - last_grant <= grant_id
- The master channel obeys AXI-Stream rules: while m_tvalid=1 && m_tready=0, m_tdata, m_tlast and m_tvalid are held stable.
- A granted input that drops tvalid mid-packet keeps the grant. The arbiter waits indefinitely; there is no timeout.
- Single-beat packets (tlast on the first beat) are legal.
- s_tready depends combinationally on m_tready. This is the only combinational input-to-output path.
- **Reset**, applied at any time including mid-packet:
  - state = IDLE
  - m_tvalid = 0, m_tdata = 0, m_tlast = 0
  - grant_id = 0
  - last_grant = NUM_INPUTS-1, so input 0 has first priority after reset
  - busy = 0
  - s_tready = 0
  - A partially transferred packet is abandoned; the upstream source must also be reset.

## Timing

- Arbitration latency: a request first seen valid in IDLE in cycle c is granted at the end of c. Its first beat can be accepted in cycle c+1 and appears on m_* in cycle c+2.
- Pass-through latency: one cycle from input acceptance to m_tvalid.
- Throughput: one beat per cycle within a packet while m_tready=1.
- Packet gap: one bubble cycle on the master channel between consecutive packets, because tlast is accepted in cycle t, IDLE arbitrates in t+1, and the next first beat is accepted in t+2.
- m_tready low stalls the granted input in the same cycle. With the register full and m_tready=0, s_tready is 0.
- Fairness: with all inputs continuously requesting, grants cycle 0,1,…,NUM_INPUTS-1,0,… (one packet each).

## Test plan

- **Reset priority:** after reset, assert s_tvalid on inputs 1 and 3 simultaneously with 2-beat packets. Required: input 1's packet on m_* first, then input 3's; grant_id goes 1 then 3; one bubble between packets.
- **Round-robin wrap:** with NUM_INPUTS=4 and all inputs continuously sending 1-beat packets, tag each tdata with its source index. Required: m_tdata sequence is 0,1,2,3,0,1; each beat separated by one idle cycle.
- **Backpressure:** send one 4-beat packet on input 2 (data 0xA0..0xA3) and toggle m_tready 1,0,0,1,0,1,1. Required: data emerges in order with no loss or duplication; m_tdata is stable while stalled; m_tlast is set only with 0xA3.
- **No interleave:** input 0 sends a 3-beat packet and drops s_tvalid for 5 cycles mid-packet while input 1 requests. Required: input 1 gets no s_tready until input 0's tlast beat is accepted; busy stays 1 throughout.
- **Reset mid-packet:** assert areset on the 2nd beat of a 4-beat packet. Required: on the next cycle m_tvalid=0, busy=0 and s_tready=0; after release, a new request on input 0 is granted first.
- **Idle:** with no s_tvalid for 20 cycles, required: m_tvalid=0, busy=0 and grant_id unchanged throughout.
